prv_trap_ctrl: RTL and testbench
================================

PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port nRST, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have inputs mal_insn, fault_insn, illegal_insn, breakpoint, mal_l, fault_l, mal_s, fault_s, env_m, each 1 bit: exception flags from the hazard unit, held until insert_pc.
REQ-004 SHALL have inputs ret, 1 (mret retiring) and pipe_clear, 1 (pipeline drained).
REQ-005 SHALL have inputs epc, 32 (faulting/interrupted PC) and badaddr, 32 (faulting address).
REQ-006 SHALL have inputs timer_int, soft_int, ext_int, each 1: interrupt levels.
REQ-007 SHALL have input mtvec, 32: trap vector base; bits [1:0] give the mode.
REQ-008 SHALL have outputs priv_pc, 32; insert_pc, 1; intr, 1 (trap pending, flush request).
REQ-009 SHALL have outputs mepc, mcause, mtval, each 32, and mie_o, 1 (mstatus.MIE).
REQ-010 SHALL have input mie_set, 1 and mie_clr, 1: CSR-path writes to MIE; mie_clr wins if both are high.

Function
REQ-011 SHALL implement the FSM states IDLE, TRAP, and RET.
REQ-012 pend_int SHALL equal mie_o AND (ext_int OR soft_int OR timer_int).
REQ-013 pend_exc SHALL be the OR of the REQ-003 flags.
REQ-014 intr SHALL be combinational: high in IDLE when pend_int or pend_exc is high, else low.
REQ-015 In IDLE with pipe_clear=1 and (pend_int or pend_exc): the FSM SHALL latch mepc<=epc, mcause, and mtval, set MPIE<=MIE and MIE<=0, then go to TRAP.
REQ-016 In IDLE with pipe_clear=1, ret=1, and no pending trap: the FSM SHALL set MIE<=MPIE and MPIE<=1, then go to RET.
REQ-017 If a trap and ret coincide, the trap SHALL win; ret is dropped.
REQ-018 TRAP and RET SHALL last exactly one cycle each, with insert_pc=1, then return to IDLE.
REQ-019 Trap PC SHALL be {mtvec[31:2],2'b00}.
REQ-020 RET PC SHALL be mepc.
REQ-021 In IDLE, insert_pc SHALL be 0 and priv_pc SHALL be 0.
REQ-022 Latency from the accepting edge to insert_pc SHALL be 1 cycle.
REQ-023 Interrupts SHALL have priority over exceptions.
REQ-024 Interrupt priority order: ext (cause 11) > soft (3) > timer (7); mcause[31]=1.
REQ-025 Exception priority order: breakpoint(3) > fault_insn(1) > mal_insn(0) > illegal_insn(2) > env_m(11) > mal_s(6) > mal_l(4) > fault_s(7) > fault_l(5); mcause[31]=0.
REQ-026 mtval SHALL take badaddr for mal_insn, fault_insn, mal_l, fault_l, mal_s, and fault_s; otherwise it SHALL be 0.
REQ-027 mie_set and mie_clr SHALL apply only in IDLE with no transition that cycle; otherwise they are ignored.
REQ-028 Without pipe_clear, the block SHALL stay in IDLE with intr held and no register update.

Reset
REQ-029 On nRST=0: state=IDLE; mepc, mcause, mtval, MIE, and MPIE = 0; priv_pc=0; insert_pc=0.
REQ-030 Reset during TRAP or RET SHALL abort immediately; insert_pc SHALL drop asynchronously.

Configuration
REQ-031 Macro PRV_VECTORED_INT_EN SHALL control vectored interrupt dispatch.
REQ-032 With PRV_VECTORED_INT_EN defined, mtvec[1:0]==2'b01, and an interrupt trap: trap PC = base + 4*cause[4:0]. Exceptions always use the base.
REQ-033 Without PRV_VECTORED_INT_EN: trap PC = base always; mtvec[1:0] is ignored.

Verification
REQ-034 illegal_insn=1, epc=0x100, mtvec=0x8000, pipe_clear=1 -> next cycle: insert_pc=1, priv_pc=0x8000, mepc=0x100, mcause=2, mtval=0.
REQ-035 mal_l=1 and fault_s=1 together, badaddr=0x2003 -> mcause=4, mtval=0x2003.
REQ-036 MIE=1, timer_int=1, ext_int=1, illegal_insn=1 -> mcause=0x8000000B, mie_o=0; then ret with mepc=0x44 -> priv_pc=0x44, mie_o=1.
REQ-037 With PRV_VECTORED_INT_EN, mtvec=0x8001, MIE=1, soft_int=1 -> priv_pc=0x800C. Without the macro -> priv_pc=0x8000.
REQ-038 breakpoint=1 with pipe_clear=0 for 3 cycles -> intr=1, insert_pc=0, mepc unchanged; pipe_clear rises -> TRAP next cycle.
REQ-039 nRST pulsed low during TRAP -> insert_pc=0 immediately; all registers 0; state IDLE.

Source files
------------

// File: rtl/prv_trap_ctrl.sv
// rtl/prv_trap_ctrl.sv - machine-mode trap entry / mret controller
// Define PRV_VECTORED_INT_EN to dispatch interrupts to base + 4*cause when mtvec mode is 1.
module prv_trap_ctrl (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        mal_insn,
   input  logic        fault_insn,
   input  logic        illegal_insn,
   input  logic        breakpoint,
   input  logic        mal_l,
   input  logic        fault_l,
   input  logic        mal_s,
   input  logic        fault_s,
   input  logic        env_m,
   input  logic        ret,
   input  logic        pipe_clear,
   input  logic [31:0] epc,
   input  logic [31:0] badaddr,
   input  logic        timer_int,
   input  logic        soft_int,
   input  logic        ext_int,
   input  logic [31:0] mtvec,
   input  logic        mie_set,
   input  logic        mie_clr,
   output logic [31:0] priv_pc,
   output logic        insert_pc,
   output logic        intr,
   output logic [31:0] mepc,
   output logic [31:0] mcause,
   output logic [31:0] mtval,
   output logic        mie_o
);

   typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

   state_t      state, state_nxt;
   logic        mie_q, mpie_q;
   logic        pend_int, pend_exc;
   logic        take_trap, take_ret;
   logic [31:0] cause_nxt, tval_nxt;
   logic [31:0] trap_pc;

   assign pend_int = mie_q & (ext_int | soft_int | timer_int);
   assign pend_exc = mal_insn | fault_insn | illegal_insn | breakpoint | mal_l |
                     fault_l | mal_s | fault_s | env_m;
   assign mie_o    = mie_q;

   // Cause and tval of the highest-priority pending event; interrupts beat exceptions.
   always_comb begin
      cause_nxt = 32'd0;
      tval_nxt  = 32'd0;
      if (pend_int) begin
         if (ext_int)       cause_nxt = 32'h8000_000B;
         else if (soft_int) cause_nxt = 32'h8000_0003;
         else               cause_nxt = 32'h8000_0007;
      end else if (breakpoint) begin
         cause_nxt = 32'd3;
      end else if (fault_insn) begin
         cause_nxt = 32'd1;
         tval_nxt  = badaddr;
      end else if (mal_insn) begin
         cause_nxt = 32'd0;
         tval_nxt  = badaddr;
      end else if (illegal_insn) begin
         cause_nxt = 32'd2;
      end else if (env_m) begin
         cause_nxt = 32'd11;
      end else if (mal_s) begin
         cause_nxt = 32'd6;
         tval_nxt  = badaddr;
      end else if (mal_l) begin
         cause_nxt = 32'd4;
         tval_nxt  = badaddr;
      end else if (fault_s) begin
         cause_nxt = 32'd7;
         tval_nxt  = badaddr;
      end else if (fault_l) begin
         cause_nxt = 32'd5;
         tval_nxt  = badaddr;
      end
   end

`ifdef PRV_VECTORED_INT_EN
   always_comb begin
      trap_pc = {mtvec[31:2], 2'b00};
      if (mtvec[1:0] == 2'b01 && mcause[31])
         trap_pc = {mtvec[31:2], 2'b00} + {25'd0, mcause[4:0], 2'b00};
   end
`else
   // Mode bits are masked off: the base is always the target.
   assign trap_pc = {mtvec[31:2], mtvec[1:0] & 2'b00};
`endif

   always_comb begin
      state_nxt = state;
      take_trap = 1'b0;
      take_ret  = 1'b0;
      insert_pc = 1'b0;
      priv_pc   = 32'd0;
      intr      = 1'b0;
      case (state)
         IDLE: begin
            intr = pend_int | pend_exc;
            if (pipe_clear) begin
               if (pend_int | pend_exc) begin
                  take_trap = 1'b1;
                  state_nxt = TRAP;
               end else if (ret) begin
                  take_ret  = 1'b1;
                  state_nxt = RET;
               end
            end
         end
         TRAP: begin
            insert_pc = 1'b1;
            priv_pc   = trap_pc;
            state_nxt = IDLE;
         end
         RET: begin
            insert_pc = 1'b1;
            priv_pc   = mepc;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         mepc   <= 32'd0;
         mcause <= 32'd0;
         mtval  <= 32'd0;
         mie_q  <= 1'b0;
         mpie_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take_trap) begin
            mepc   <= epc;
            mcause <= cause_nxt;
            mtval  <= tval_nxt;
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
         end else if (take_ret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end else if (state == IDLE) begin
            // CSR writes only land on quiet IDLE cycles; clear dominates set.
            if (mie_clr)      mie_q <= 1'b0;
            else if (mie_set) mie_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// tb/tb_prv_trap_ctrl.sv - scoreboard bench for prv_trap_ctrl
module tb_prv_trap_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        mal_insn, fault_insn, illegal_insn, breakpoint;
   logic        mal_l, fault_l, mal_s, fault_s, env_m;
   logic        ret, pipe_clear;
   logic [31:0] epc, badaddr, mtvec;
   logic        timer_int, soft_int, ext_int;
   logic        mie_set, mie_clr;
   logic [31:0] priv_pc, mepc, mcause, mtval;
   logic        insert_pc, intr, mie_o;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic [31:0] mtval;
      logic        mie;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

`ifdef PRV_VECTORED_INT_EN
   localparam logic [31:0] SOFT_PC  = 32'h0000_800C;
   localparam logic [31:0] TIMER_PC = 32'h0000_801C;
`else
   localparam logic [31:0] SOFT_PC  = 32'h0000_8000;
   localparam logic [31:0] TIMER_PC = 32'h0000_8000;
`endif

   always #5 CLK = ~CLK;

   prv_trap_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .mal_insn(mal_insn), .fault_insn(fault_insn), .illegal_insn(illegal_insn),
      .breakpoint(breakpoint), .mal_l(mal_l), .fault_l(fault_l), .mal_s(mal_s),
      .fault_s(fault_s), .env_m(env_m), .ret(ret), .pipe_clear(pipe_clear),
      .epc(epc), .badaddr(badaddr), .timer_int(timer_int), .soft_int(soft_int),
      .ext_int(ext_int), .mtvec(mtvec), .mie_set(mie_set), .mie_clr(mie_clr),
      .priv_pc(priv_pc), .insert_pc(insert_pc), .intr(intr), .mepc(mepc),
      .mcause(mcause), .mtval(mtval), .mie_o(mie_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (nRST && insert_pc) begin
         if (q.size() == 0) begin
            check("spurious_insert", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, "_pc"},     priv_pc, e.pc);
            check({e.tag, "_mepc"},   mepc,    e.mepc);
            check({e.tag, "_mcause"}, mcause,  e.mcause);
            check({e.tag, "_mtval"},  mtval,   e.mtval);
            check({e.tag, "_mie"},    {31'd0, mie_o}, {31'd0, e.mie});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      {mal_insn, fault_insn, illegal_insn, breakpoint, mal_l, fault_l, mal_s, fault_s, env_m} = '0;
      {ret, pipe_clear, timer_int, soft_int, ext_int, mie_set, mie_clr} = '0;
   endtask

   function automatic exp_t mk(input string tag, input logic [31:0] pc, input logic [31:0] mepc_v,
                               input logic [31:0] cause, input logic [31:0] tval, input logic mie);
      exp_t e;
      e.tag = tag; e.pc = pc; e.mepc = mepc_v; e.mcause = cause; e.mtval = tval; e.mie = mie;
      return e;
   endfunction

   // Caller sets up the event inputs; this accepts it, then waits for the scoreboard to drain.
   task automatic fire(input exp_t e);
      pipe_clear = 1'b1;
      q.push_back(e);
      tick();
      clear_inputs();
      for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge CLK);
      #1;
      check({e.tag, "_drain"}, q.size(), 32'd0);
      tick();
   endtask

   initial begin
      nRST = 1'b0;
      clear_inputs();
      epc = 32'd0; badaddr = 32'd0; mtvec = 32'h0000_8000;
      repeat (2) @(negedge CLK);
      check("rst_insert", {31'd0, insert_pc}, 32'd0);
      check("rst_pc",     priv_pc, 32'd0);
      check("rst_mepc",   mepc,    32'd0);
      check("rst_mcause", mcause,  32'd0);
      check("rst_mie",    {31'd0, mie_o}, 32'd0);
      tick();
      nRST = 1'b1;
      tick();

      illegal_insn = 1'b1; epc = 32'h100;
      @(negedge CLK);
      check("illegal_intr", {31'd0, intr}, 32'd1);
      fire(mk("illegal", 32'h8000, 32'h100, 32'd2, 32'd0, 1'b0));

      mal_l = 1'b1; fault_s = 1'b1; badaddr = 32'h2003; epc = 32'h200;
      fire(mk("mal_l_fault_s", 32'h8000, 32'h200, 32'd4, 32'h2003, 1'b0));

      breakpoint = 1'b1; mal_insn = 1'b1; illegal_insn = 1'b1; epc = 32'h300;
      fire(mk("bkpt", 32'h8000, 32'h300, 32'd3, 32'd0, 1'b0));

      fault_insn = 1'b1; mal_insn = 1'b1; badaddr = 32'hABC; epc = 32'h304;
      fire(mk("fault_insn", 32'h8000, 32'h304, 32'd1, 32'hABC, 1'b0));

      env_m = 1'b1; mal_s = 1'b1; fault_l = 1'b1; epc = 32'h308;
      fire(mk("env_m", 32'h8000, 32'h308, 32'd11, 32'd0, 1'b0));

      fault_l = 1'b1; badaddr = 32'h55; epc = 32'h30C;
      fire(mk("fault_l", 32'h8000, 32'h30C, 32'd5, 32'h55, 1'b0));

      soft_int = 1'b1;
      @(negedge CLK);
      check("masked_int_intr", {31'd0, intr}, 32'd0);
      tick();
      soft_int = 1'b0; mie_set = 1'b1;
      tick();
      mie_set = 1'b0;
      @(negedge CLK);
      check("mie_set", {31'd0, mie_o}, 32'd1);
      tick();

      timer_int = 1'b1; ext_int = 1'b1; illegal_insn = 1'b1; epc = 32'h44;
      fire(mk("ext_int", 32'h8000, 32'h44, 32'h8000_000B, 32'd0, 1'b0));
      ret = 1'b1;
      fire(mk("mret1", 32'h44, 32'h44, 32'h8000_000B, 32'd0, 1'b1));

      mie_set = 1'b1; mie_clr = 1'b1;
      tick();
      clear_inputs();
      @(negedge CLK);
      check("mie_clr_wins", {31'd0, mie_o}, 32'd0);
      tick();

      ret = 1'b1; mie_clr = 1'b1;
      fire(mk("mret_ign_clr", 32'h44, 32'h44, 32'h8000_000B, 32'd0, 1'b1));

      mtvec = 32'h8001; soft_int = 1'b1; epc = 32'h500;
      fire(mk("soft_vec", SOFT_PC, 32'h500, 32'h8000_0003, 32'd0, 1'b0));
      ret = 1'b1;
      fire(mk("mret2", 32'h500, 32'h500, 32'h8000_0003, 32'd0, 1'b1));

      timer_int = 1'b1; soft_int = 1'b1; epc = 32'h600;
      fire(mk("soft_over_timer", SOFT_PC, 32'h600, 32'h8000_0003, 32'd0, 1'b0));
      ret = 1'b1;
      fire(mk("mret3", 32'h600, 32'h600, 32'h8000_0003, 32'd0, 1'b1));

      timer_int = 1'b1; epc = 32'h700;
      fire(mk("timer_vec", TIMER_PC, 32'h700, 32'h8000_0007, 32'd0, 1'b0));
      illegal_insn = 1'b1; epc = 32'h704;
      fire(mk("exc_base", 32'h8000, 32'h704, 32'd2, 32'd0, 1'b0));
      mtvec = 32'h8000;

      illegal_insn = 1'b1; ret = 1'b1; epc = 32'h800;
      fire(mk("trap_over_ret", 32'h8000, 32'h800, 32'd2, 32'd0, 1'b0));
      @(negedge CLK);
      check("ret_dropped", {31'd0, insert_pc}, 32'd0);
      tick();

      breakpoint = 1'b1; epc = 32'h900;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("hold_intr",   {31'd0, intr}, 32'd1);
         check("hold_insert", {31'd0, insert_pc}, 32'd0);
         check("hold_mepc",   mepc, 32'h800);
         tick();
      end
      fire(mk("bkpt_late", 32'h8000, 32'h900, 32'd3, 32'd0, 1'b0));

      illegal_insn = 1'b1; epc = 32'hA00; badaddr = 32'h1234; pipe_clear = 1'b1;
      tick();
      clear_inputs();
      check("pre_rst_insert", {31'd0, insert_pc}, 32'd1);
      #1 nRST = 1'b0;
      #1;
      check("arst_insert", {31'd0, insert_pc}, 32'd0);
      check("arst_pc",     priv_pc, 32'd0);
      check("arst_mepc",   mepc,    32'd0);
      check("arst_mcause", mcause,  32'd0);
      check("arst_mtval",  mtval,   32'd0);
      check("arst_mie",    {31'd0, mie_o}, 32'd0);
      tick();
      nRST = 1'b1;
      @(negedge CLK);
      check("post_rst_insert", {31'd0, insert_pc}, 32'd0);
      check("post_rst_intr",   {31'd0, intr}, 32'd0);
      tick();
      check("sb_empty", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
